// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared constants for the multicycle MIPS control unit
// Holds the FSM state encodings, the opcode values and the datapath mux codes
// used by the control unit, its opcode decoder and the datapath.
package mips_ctrl_pkg;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_ILLEGAL = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUB_REG   = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_IMMSH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - control/datapath bundle for the multicycle MIPS core
// Inputs to control: op (IR[31:26]), zero (ALU flag), mem_ready (memory handshake).
// Outputs from control: PC/IR/regfile enables, memory requests and datapath mux selects.
// master = control unit, slave = datapath.
interface mips_ctrl_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;

    modport master (
        input  op, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op
    );
endinterface

// File: rtl/mips_op_decode.sv
// rtl/mips_op_decode.sv - opcode decoder for the multicycle MIPS control FSM
// Ports: op (IR[31:26]) in; decode_next (state after DECODE), is_beq, is_bne out.
module mips_op_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output logic [3:0] decode_next,
    output logic       is_beq,
    output logic       is_bne
);

    always_comb begin
        decode_next = S_ILLEGAL;
        case (op)
            OP_RTYPE:      decode_next = S_EXEC;
            OP_LW, OP_SW:  decode_next = S_MEMADR;
            OP_BEQ, OP_BNE: decode_next = S_BRANCH;
            OP_ADDI:       decode_next = S_ADDIEX;
            OP_J:          decode_next = S_JUMP;
            default:       decode_next = S_ILLEGAL;
        endcase
    end

    assign is_beq = (op == OP_BEQ);
    assign is_bne = (op == OP_BNE);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - Moore FSM control unit for the multicycle MIPS core
// Ports: CLK, reset (sync, active-high), bus (mips_ctrl_if.master: op/zero/mem_ready
// in, datapath enables and selects out), state (current FSM encoding, debug).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               CLK,
    input  logic               reset,
    mips_ctrl_if.master        bus,
    output logic [STATE_W-1:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_d;

    logic [3:0] decode_next;
    logic       is_beq;
    logic       is_bne;

    logic       pc_write;
    logic       branch_act;
    logic       iord_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic       reg_dst_c;
    logic       mem_to_reg_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;
    logic [1:0] pc_src_c;
    logic       illegal_c;
    logic       pc_en_c;

    mips_op_decode u_op_decode (
        .op          (bus.op),
        .decode_next (decode_next),
        .is_beq      (is_beq),
        .is_bne      (is_bne)
    );

    always_comb begin
        state_d      = S_FETCH;
        pc_write     = 1'b0;
        branch_act   = 1'b0;
        iord_c       = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = ALUB_REG;
        alu_op_c     = ALUOP_ADD;
        pc_src_c     = PCSRC_ALU;
        illegal_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = ALUB_FOUR;
                // IR load and PC+4 are tied to the ready cycle so a stalled
                // fetch never double-increments the PC.
                ir_write_c  = bus.mem_ready;
                pc_write    = bus.mem_ready;
                state_d     = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b_c = ALUB_IMMSH;
                state_d     = decode_next;
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = ALUB_IMM;
                if (bus.op == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (bus.op == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                state_d    = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
            end
            S_MEMWR: begin
                // Held steady through the wait; memory commits on the ready cycle.
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                state_d     = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = ALUB_REG;
                alu_op_c    = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALUOP_SUB;
                pc_src_c    = PCSRC_ALUOUT;
                branch_act  = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = ALUB_IMM;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_c = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src_c = PCSRC_JUMP;
            end
            S_ILLEGAL: begin
                illegal_c = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        pc_en_c = pc_write
                | (branch_act & is_beq & bus.zero)
                | (branch_act & is_bne & ~bus.zero);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset masks every output so no memory request or PC load leaks out
    // while the FSM is being forced back to FETCH.
    assign bus.pc_en      = ~reset & pc_en_c;
    assign bus.iord       = ~reset & iord_c;
    assign bus.mem_read   = ~reset & mem_read_c;
    assign bus.mem_write  = ~reset & mem_write_c;
    assign bus.ir_write   = ~reset & ir_write_c;
    assign bus.reg_write  = ~reset & reg_write_c;
    assign bus.reg_dst    = ~reset & reg_dst_c;
    assign bus.mem_to_reg = ~reset & mem_to_reg_c;
    assign bus.alu_src_a  = ~reset & alu_src_a_c;
    assign bus.alu_src_b  = reset ? 2'b00 : alu_src_b_c;
    assign bus.alu_op     = reset ? 2'b00 : alu_op_c;
    assign bus.pc_src     = reset ? 2'b00 : pc_src_c;
    assign bus.illegal_op = ~reset & illegal_c;
    assign state          = reset ? '0 : STATE_W'(state_q);

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control unit for the MIPS core. It replaces the single-cycle combinational control with a Moore FSM that sequences one shared ALU, one unified instruction/data memory port, the register file and the PC over 3–5 cycles per instruction. It sits between the instruction register's opcode/funct fields, the ALU zero flag, the memory ready handshake, and every datapath mux and enable.

## Interface
- `STATE_W`, default 4: width of the state debug output.
- `CLK` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: IR[31:26].
- `zero` in 1: ALU zero flag, valid in BRANCH.
- `mem_ready` in 1: memory completes the current read or write in this cycle.
- `pc_en` out 1: PC load enable, `pc_write | (beq & zero) | (bne & ~zero)`.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: IR load.
- `reg_write` out 1: register file write.
- `reg_dst` out 1: write register select, 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write data select, 0 = ALUOut, 1 = MDR.
- `alu_src_a` out 1: ALU A select, 0 = PC, 1 = reg A.
- `alu_src_b` out 2: ALU B select, 00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = funct-decoded.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op` out 1: high for the single cycle spent in ILLEGAL.
- `state` out `STATE_W`: current state encoding.

## Operation
States and encodings, with the outputs asserted in each (all unlisted outputs are 0):
- FETCH (0): `mem_read`, `alu_src_b`=01, `alu_op`=00, `pc_src`=00.
  - `ir_write` and `pc_write` are asserted only when `mem_ready`=1.
  - Stays in FETCH while `mem_ready`=0. Goes to DECODE when `mem_ready`=1.
- DECODE (1): `alu_src_b`=11, `alu_op`=00. Next state by `op`:
  - 000000 → EXEC
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 (beq) or 000101 (bne) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - any other opcode → ILLEGAL
- MEMADR (2): `alu_src_a`=1, `alu_src_b`=10. Next is MEMRD for lw, MEMWR for sw.
- MEMRD (3): `mem_read`, `iord`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB (4): `reg_write`, `mem_to_reg`=1, `reg_dst`=0. Next is FETCH.
- MEMWR (5): `mem_write`, `iord`=1. Holds until `mem_ready`, then goes to FETCH.
- EXEC (6): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next is ALUWB.
- ALUWB (7): `reg_write`, `reg_dst`=1. Next is FETCH.
- BRANCH (8): `alu_src_a`=1, `alu_op`=01, `pc_src`=01.
  - Internal `beq`=1 when `op`=000100; `bne`=1 when `op`=000101.
  - Next is FETCH.
- ADDIEX (9): `alu_src_a`=1, `alu_src_b`=10. Next is ADDIWB.
- ADDIWB (10): `reg_write`, `reg_dst`=0. Next is FETCH.
- JUMP (11): `pc_write`, `pc_src`=10. Next is FETCH.
- ILLEGAL (12): `illegal_op`=1. The PC is left at PC+4. Next is FETCH.
- Encodings 13–15 are unreachable. If ever entered, the FSM goes to FETCH with all outputs 0.

Boundary rules:
- `mem_write` is held constant for every cycle of a MEMWR wait. Memory commits exactly once, in the cycle `mem_write & mem_ready`.
- `pc_en` never asserts in FETCH while `mem_ready`=0. This guarantees exactly one PC+4 per instruction.
- `op` is sampled only in DECODE, MEMADR and BRANCH. IR is stable in those states because `ir_write`=0.

## Timing
- Reset:
  - `reset`=1 at a rising edge sets `state`=FETCH, regardless of the current state, including mid-MEMWR or mid-wait.
  - While `reset` is high, all outputs are forced to 0, including `mem_read` and `pc_en`.
- Cycles per instruction with zero-wait memory: R-type 4, lw 5, sw 4, addi 4, beq/bne 3, j 3, illegal 3.
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- All outputs are combinational from `state`. The only exceptions are `pc_en` (from `zero` and `mem_ready`) and `ir_write` (from `mem_ready`).
- No output depends on `op` except in DECODE, MEMADR and BRANCH.

## Structure
- The shared package `mips_ctrl_pkg` holds:
  - the state encodings;
  - the opcode constants (RTYPE, LW, SW, BEQ, BNE, ADDI, J);
  - the `alu_src_b`, `alu_op` and `pc_src` code constants.
- One combinational sub-module, `mips_op_decode`, maps `op` to the DECODE next state and drives the `beq`/`bne` qualifiers.
- The FSM register and output decode live in the top module.

## Test plan
- Reset mid-MEMWR with `mem_ready`=0: one cycle later `state`=0, `mem_write`=0, and no memory write occurs.
- lw (op=100011), `mem_ready`=1 throughout: `state` sequence is 0,1,2,3,4,0; `reg_write`=1 and `mem_to_reg`=1 only in cycle 5; `pc_en`=1 only in cycle 1.
- sw (op=101011), `mem_ready` low for 2 cycles in MEMWR:
  - state sequence is 0,1,2,5,5,5,0;
  - `mem_write` is high for 3 cycles;
  - exactly one commit.
- beq and bne:
  - beq with `zero`=1: `pc_en`=1 and `pc_src`=01 in BRANCH.
  - beq with `zero`=0: `pc_en`=0 in BRANCH.
  - bne with `zero`=0: `pc_en`=1.
- FETCH with `mem_ready`=0 for 3 cycles: `ir_write`=0 and `pc_en`=0 until the ready cycle, then exactly one pulse of each.
- op=111111: state sequence is 0,1,12,0; `illegal_op` is high for exactly 1 cycle; `reg_write` and `mem_write` are never asserted.
